operand_stager: RTL

- Upstream feeder for the operand-compare stage.
- Collects two WIDTH-bit operands, delivered one beat at a time on a valid/ready byte stream, into a registered pair (in0 = first beat, in1 = second beat).
- Presents the pair with out_valid until the consumer accepts it with out_ready.
- Keeps a wrapping count of pairs delivered.

---
 rtl/operand_stager.sv | 135 +++++++++++++
 1 files changed

// File: rtl/operand_stager.sv
// -----------------------------------------------------------------------------
// operand_stager
//
// Upstream feeder for the operand-compare stage. It collects two WIDTH-bit
// operands, one beat at a time, from a valid/ready stream into a registered
// pair: in0 holds the first beat and in1 holds the second. The pair is shown
// with out_valid until the consumer takes it with out_ready. The block also
// keeps a wrapping count of the pairs it has handed off.
//
// Optional feature (compile-time macro OPERAND_STAGER_OVERLAP_EN):
//   While FULL, the block may accept a new first beat in the same cycle that
//   the consumer takes the current pair. This gives one pair every 2 cycles.
//   Without the macro, in_ready is 0 in FULL and a pair takes at least
//   3 cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset; it has the highest priority
//   clear      in   synchronous abort of a partly or fully staged pair
//   in_data    in   operand beat (WIDTH)
//   in_valid   in   in_data is valid
//   in_ready   out  stager can accept a beat (combinational)
//   in0        out  first staged operand (registered, WIDTH)
//   in1        out  second staged operand (registered, WIDTH)
//   out_valid  out  in0/in1 form a complete pair
//   out_ready  in   consumer accepts the pair
//   pending_a  out  first operand is captured and the second is awaited
//   pair_count out  pairs handed off, modulo 2^CNT_W (CNT_W)
// -----------------------------------------------------------------------------
module operand_stager #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] in0,
    output logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pending_a,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   handoff;

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples values from before the edge, whatever order the processes run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. clear overrides everything except rst.
    // NOTE: state_next gets its default value first, so no path through the
    // case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY:   if (accept) state_next = HAVE_A;
                HAVE_A:  if (accept) state_next = FULL;
                FULL: begin
                    if (handoff) begin
`ifdef OPERAND_STAGER_OVERLAP_EN
                        // A beat taken during handoff starts the next pair.
                        state_next = accept ? HAVE_A : EMPTY;
`else
                        state_next = EMPTY;
`endif
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Output decode. out_valid and pending_a come straight from the state
    // register, so they have no combinational input paths.
    always_comb begin
        out_valid = (state == FULL);
        pending_a = (state == HAVE_A);
`ifdef OPERAND_STAGER_OVERLAP_EN
        in_ready  = !clear && ((state != FULL) || out_ready);
`else
        in_ready  = !clear && (state != FULL);
`endif
    end

    // Operand capture. accept already includes !clear through in_ready.
    // A beat accepted in FULL (overlap only) is the first beat of the next pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            in0 <= '0;
            in1 <= '0;
        end else if (accept) begin
            if (state == HAVE_A) begin
                in1 <= in_data;
            end else begin
                in0 <= in_data;
            end
        end
    end

    // Pair counter. A handoff in the same cycle as clear is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_count <= '0;
        end else if (handoff && !clear) begin
            pair_count <= pair_count + 1'b1;
        end
    end

endmodule
